alarm_clock_mode_ctrl: RTL and testbench

Central mode sequencer for the alarm clock. It consumes one-cycle button pulses from the per-button rising-edge detectors and arbitrates between simultaneous presses. It sequences the clock through its time-adjust and alarm-adjust modes, and issues single-cycle increment/decrement commands to the hour/minute counters. It also owns the alarm-ringing latch, and sits between the edge-detector bank and the time/alarm counter datapath.

---
 rtl/alarm_clock_mode_ctrl_pkg.sv | 22 ++
 rtl/alarm_clock_mode_ctrl_if.sv | 24 ++
 rtl/alarm_clock_mode_ctrl_inactivity_timer.sv | 21 ++
 rtl/alarm_clock_mode_ctrl.sv | 68 ++++++
 tb/tb_alarm_clock_mode_ctrl.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/alarm_clock_mode_ctrl_pkg.sv
// alarm_clock_pkg: state encodings, button priority indices and defaults shared by the mode controller
package alarm_clock_pkg;
  localparam logic [2:0] ST_CLOCK = 3'd0;
  localparam logic [2:0] ST_T_HR = 3'd1;
  localparam logic [2:0] ST_T_MIN = 3'd2;
  localparam logic [2:0] ST_A_HR = 3'd3;
  localparam logic [2:0] ST_A_MIN = 3'd4;
  localparam logic [2:0] BTN_C = 3'd0;
  localparam logic [2:0] BTN_L = 3'd1;
  localparam logic [2:0] BTN_R = 3'd2;
  localparam logic [2:0] BTN_U = 3'd3;
  localparam logic [2:0] BTN_D = 3'd4;
  localparam logic [2:0] BTN_NONE = 3'd5;
  localparam int AUTO_EXIT_TICKS_DEF = 30;
  // Bit i of b is the button with index i; the lowest set index wins, BTN_NONE if idle.
  function automatic logic [2:0] btn_pick(input logic [4:0] b);
    logic [2:0] r;
    r = BTN_NONE;
    for (int i = 4; i >= 0; i--) r = b[i] ? 3'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/alarm_clock_mode_ctrl_if.sv
// alarm_clock_mode_ctrl_if: button/tick/match inputs and mode/command outputs of the mode controller
interface alarm_clock_mode_ctrl_if;
  logic btn_c;
  logic btn_l;
  logic btn_r;
  logic btn_u;
  logic btn_d;
  logic tick_1hz;
  logic alarm_match;
  logic adj_mode;
  logic sel_alarm;
  logic sel_min;
  logic inc;
  logic dec;
  logic alarm_ringing;
  modport master (
    output btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_match,
    input adj_mode, sel_alarm, sel_min, inc, dec, alarm_ringing
  );
  modport slave (
    input btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_match,
    output adj_mode, sel_alarm, sel_min, inc, dec, alarm_ringing
  );
endinterface

// File: rtl/alarm_clock_mode_ctrl_inactivity_timer.sv
// inactivity_timer: saturating tick counter with clear; hit flags the limit (LIMIT=0 never hits)
module inactivity_timer
  import alarm_clock_pkg::*;
#(
  parameter int LIMIT = AUTO_EXIT_TICKS_DEF,
  localparam int W = LIMIT > 0 ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] cnt;
  assign hit = (LIMIT != 0) && (cnt == W'(LIMIT));
  // Count ticks up to the limit; clear has priority over counting.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/alarm_clock_mode_ctrl.sv
// alarm_clock_mode_ctrl: button-driven mode sequencer, inc/dec commands, inactivity exit and alarm latch
module alarm_clock_mode_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int AUTO_EXIT_TICKS = AUTO_EXIT_TICKS_DEF
) (
  input logic clk,
  input logic rst,
  alarm_clock_mode_ctrl_if.slave bus
);
  logic [2:0] state, nstate, acc;
  logic armed, hit, in_clk, any;
  assign acc = btn_pick({bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l, bus.btn_c});
  assign any = acc != BTN_NONE;
  assign in_clk = state == ST_CLOCK;
  // Timer is held clear in CLOCK (so entry starts at 0), on any accepted press and on timeout.
  inactivity_timer #(.LIMIT(AUTO_EXIT_TICKS)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(in_clk || any || hit),
    .en(bus.tick_1hz),
    .hit(hit)
  );
  // Next mode: a press while ringing only silences; in adjust, presses beat the timeout.
  always_comb begin
    nstate = state;
    if (in_clk) nstate = (acc == BTN_C && !bus.alarm_ringing) ? ST_T_HR : ST_CLOCK;
    else
      case (acc)
        BTN_C: nstate = ST_CLOCK;
        BTN_R: nstate = state == ST_A_MIN ? ST_T_HR : state + 3'd1;
        BTN_L: nstate = state == ST_T_HR ? ST_A_MIN : state - 3'd1;
        BTN_U, BTN_D: nstate = state;
        default: nstate = hit ? ST_CLOCK : state;
      endcase
  end
  // Mode register with outputs decoded from the next mode, plus one-cycle field commands.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_CLOCK;
      bus.adj_mode <= 1'b0;
      bus.sel_alarm <= 1'b0;
      bus.sel_min <= 1'b0;
      bus.inc <= 1'b0;
      bus.dec <= 1'b0;
    end else begin
      state <= nstate;
      bus.adj_mode <= nstate != ST_CLOCK;
      bus.sel_alarm <= nstate == ST_A_HR || nstate == ST_A_MIN;
      bus.sel_min <= nstate == ST_T_MIN || nstate == ST_A_MIN;
      bus.inc <= !in_clk && acc == BTN_U;
      bus.dec <= !in_clk && acc == BTN_D;
    end
  // Alarm latch: only acts in CLOCK; silencing disarms until the match level drops.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.alarm_ringing <= 1'b0;
      armed <= 1'b1;
    end else if (in_clk) begin
      if (bus.alarm_ringing && any) begin
        bus.alarm_ringing <= 1'b0;
        armed <= 1'b0;
      end else begin
        if (armed && bus.alarm_match) bus.alarm_ringing <= 1'b1;
        if (!bus.alarm_match) armed <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alarm_clock_mode_ctrl.sv
// tb_alarm_clock_mode_ctrl: directed + random stimulus against a mode-ring reference model, queue scoreboard
module tb_alarm_clock_mode_ctrl;
  localparam int LIM = 3;
  localparam logic [4:0] C = 5'b00001, L = 5'b00010, R = 5'b00100, U = 5'b01000, D = 5'b10000, N = 5'b00000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  int mode, idle;
  bit ring, armed;
  logic match;
  alarm_clock_mode_ctrl_if bus();
  alarm_clock_mode_ctrl #(.AUTO_EXIT_TICKS(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [5:0] outs();
    return {bus.adj_mode, bus.sel_alarm, bus.sel_min, bus.inc, bus.dec, bus.alarm_ringing};
  endfunction
  task automatic chk(input string n, input logic [5:0] got, input logic [5:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (adj,sel_alarm,sel_min,inc,dec,ring) t=%0t", n, got, e, $time);
    end
  endtask
  task automatic model_reset();
    mode = 0;
    idle = 0;
    ring = 0;
    armed = 1;
  endtask
  // mode: 0 = CLOCK, 1..4 = positions on the adjust ring T_HR, T_MIN, A_HR, A_MIN.
  task automatic step(input logic [4:0] b, input logic t, input logic m);
    int a;
    bit e_inc, e_dec;
    @(negedge clk);
    {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l, bus.btn_c} = b;
    bus.tick_1hz = t;
    bus.alarm_match = m;
    a = 5;
    for (int i = 0; i < 5; i++) if (b[i] && a == 5) a = i;
    e_inc = mode != 0 && a == 3;
    e_dec = mode != 0 && a == 4;
    if (mode == 0) begin
      idle = 0;
      if (ring && a != 5) begin
        ring = 0;
        armed = 0;
      end else begin
        if (armed && m) ring = 1;
        if (!m) armed = 1;
        if (a == 0) mode = 1;
      end
    end else if (a != 5) begin
      idle = 0;
      if (a == 0) mode = 0;
      else if (a == 2) mode = mode % 4 + 1;
      else if (a == 1) mode = (mode + 2) % 4 + 1;
    end else if (idle == LIM) begin
      mode = 0;
      idle = 0;
    end else if (t) idle++;
    exp_q.push_back({mode != 0, mode >= 3, mode == 2 || mode == 4, e_inc, e_dec, ring});
  endtask
  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outs", outs(), e);
      end
    end
  end
  initial begin
    {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l, bus.btn_c} = '0;
    bus.tick_1hz = 1'b0;
    bus.alarm_match = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 6'b0);
    rst = 1'b1;
    step(N, 0, 0);
    step(C, 0, 0);
    repeat (4) step(R, 0, 0);
    step(L, 0, 0);
    step(C, 0, 0);
    step(C, 0, 0);
    step(R, 0, 0);
    step(U, 0, 0);
    step(N, 0, 0);
    step(D, 0, 0);
    step(N, 0, 0);
    step(U | D, 0, 0);
    step(N, 0, 0);
    step(C | U, 0, 0);
    step(N, 0, 0);
    step(C, 0, 0);
    repeat (3) step(N, 1, 0);
    repeat (2) step(N, 0, 0);
    step(C, 0, 0);
    repeat (2) step(N, 1, 0);
    step(U, 0, 0);
    repeat (3) step(N, 1, 0);
    repeat (2) step(N, 0, 0);
    repeat (2) step(N, 0, 1);
    step(L, 0, 1);
    repeat (2) step(N, 0, 1);
    step(N, 0, 0);
    repeat (2) step(N, 0, 1);
    step(R, 0, 1);
    step(C, 0, 0);
    step(R, 0, 0);
    step(R, 0, 0);
    step(U, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset", outs(), 6'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    match = 1'b0;
    repeat (2000) begin
      if ($urandom_range(19) == 0) match = ~match;
      step({$urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
            $urandom_range(7) == 0, $urandom_range(9) == 0}, $urandom_range(3) == 0, match);
    end
    step(N, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
